// File: rtl/acs_pi_sequencer_pkg.sv
// Shared definitions for the ADPLL PI loop-filter sequencer.
package acs_pi_sequencer_pkg;

    localparam int              MAG_W   = 5;
    localparam logic [MAG_W-1:0] MAG_MAX = 5'd31;

    // Fixed 4-step schedule around the single shared add/subtract unit.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_INTEG = 2'd1,
        S_PROP  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Sign-magnitude word: sign 1 means negative.
    typedef struct packed {
        logic             sign;
        logic [MAG_W-1:0] mag;
    } sm_t;

endpackage

// File: rtl/acs_pi_sequencer_sm_acs_sat.sv
// Combinational saturating sign-magnitude add/subtract, shared by both PI paths.
module sm_acs_sat
    import acs_pi_sequencer_pkg::*;
(
    input  sm_t a,
    input  sm_t b,
    output sm_t y
);

    logic [MAG_W:0] sum;

    // Add like signs with saturation, subtract unlike signs; never emit -0.
    always_comb begin
        y   = '0;
        sum = {1'b0, a.mag} + {1'b0, b.mag};
        if (a.mag == '0) begin
            y = b;
        end else if (b.mag == '0) begin
            y = a;
        end else if (a.sign == b.sign) begin
            y.sign = a.sign;
            y.mag  = sum[MAG_W] ? MAG_MAX : sum[MAG_W-1:0];
        end else if (a.mag >= b.mag) begin
            y.sign = a.sign;
            y.mag  = a.mag - b.mag;
        end else begin
            y.sign = b.sign;
            y.mag  = b.mag - a.mag;
        end
        if (y.mag == '0) begin
            y.sign = 1'b0;
        end
    end

endmodule

// File: rtl/acs_pi_sequencer.sv
// PI loop filter: one shared sign-magnitude adder stepped through INTEG then PROP.
module acs_pi_sequencer
    import acs_pi_sequencer_pkg::*;
#(
    parameter int KP_SHIFT = 0,
    parameter int KI_SHIFT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             err_valid,
    output logic             err_ready,
    input  logic             err_sign,
    input  logic [MAG_W-1:0] err_mag,
    input  logic             clear_integ,
    output logic             ctrl_valid,
    output logic             ctrl_sign,
    output logic [MAG_W-1:0] ctrl_mag,
    output logic             integ_sign,
    output logic [MAG_W-1:0] integ_mag,
    output logic             busy
);

    state_t state, state_next;
    sm_t    sample, integ, ctrl;
    sm_t    ki_op, kp_op, op_a, sum;

    // State register; reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        state_next = state;
        err_ready  = 1'b0;
        busy       = 1'b1;
        ctrl_valid = 1'b0;
        case (state)
            S_IDLE: begin
                err_ready = 1'b1;
                busy      = 1'b0;
                if (err_valid) begin
                    state_next = S_INTEG;
                end
            end
            S_INTEG: state_next = S_PROP;
            S_PROP:  state_next = S_DONE;
            S_DONE: begin
                ctrl_valid = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Operand muxing: the sample term is scaled per path; the other operand is always integ.
    always_comb begin
        ki_op.sign = sample.sign;
        ki_op.mag  = sample.mag >> KI_SHIFT;
        kp_op.sign = sample.sign;
        kp_op.mag  = sample.mag >> KP_SHIFT;
        op_a       = (state == S_PROP) ? kp_op : ki_op;
    end

    sm_acs_sat u_acs (
        .a (op_a),
        .b (integ),
        .y (sum)
    );

    // Sample, integrator and control-word registers; clear_integ wins over the INTEG update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample <= '0;
            integ  <= '0;
            ctrl   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear_integ) integ <= '0;
                    if (err_valid) begin
                        sample.sign <= err_sign;
                        sample.mag  <= err_mag;
                    end
                end
                S_INTEG: integ <= clear_integ ? '0 : sum;
                S_PROP: begin
                    ctrl <= sum;
                    if (clear_integ) integ <= '0;
                end
                default: begin
                    if (clear_integ) integ <= '0;
                end
            endcase
        end
    end

    assign ctrl_sign  = ctrl.sign;
    assign ctrl_mag   = ctrl.mag;
    assign integ_sign = integ.sign;
    assign integ_mag  = integ.mag;

endmodule
